// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core (FIPS 46-3), UNROLL rounds per clock, valid/ready on both sides.
// Optional DES_DEC_ENCRYPT_EN adds a `mode` input selecting encryption (mode=1) or decryption.
module des_decrypt_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
`ifdef DES_DEC_ENCRYPT_EN
  input  logic        mode,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_t;

  localparam int unsigned IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int unsigned E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int unsigned P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  // Entry (row*16+col) of each box sits at nibble index from the MSB.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_fwd(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TAB[i]];
    return y;
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[64-IP_TAB[i]] = x[63-i];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TAB[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_TAB[i]];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  six;
    logic [5:0]  idx;
    x = '0;
    s = '0;
    y = '0;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TAB[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      idx = {six[5], six[0], six[4:1]};
      s[31-4*b -: 4] = SBOX[b][255-4*int'(idx) -: 4];
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_TAB[i]];
    return y;
  endfunction

  // Right-rotation amounts that walk the key schedule backwards from K16 (no rotate) to K1.
  function automatic logic [1:0] dec_rot(input int unsigned rnd);
    if (rnd == 1) return 2'd0;
    if (rnd == 2 || rnd == 9 || rnd == 16) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
    case (s)
      2'd0:    return x;
      2'd1:    return {x[0], x[27:1]};
      default: return {x[1:0], x[27:2]};
    endcase
  endfunction

`ifdef DES_DEC_ENCRYPT_EN
  function automatic logic [1:0] enc_rot(input int unsigned rnd);
    if (rnd == 1 || rnd == 2 || rnd == 9 || rnd == 16) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
    if (s == 2'd1) return {x[26:0], x[27]};
    return {x[25:0], x[27:26]};
  endfunction

  logic mode_q;
`endif

  state_t      state_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [4:0]  cnt_q;
  logic [4:0]  cnt_d;

  logic [63:0] ip_in;
  logic [55:0] cd_in;
  logic [31:0] l_n, r_n, tmp;
  logic [27:0] c_n, d_n;
  logic [47:0] sub;
  int unsigned rnd;

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign cnt_d    = cnt_q + 5'(UNROLL);

  always_comb begin
    ip_in = ip_fwd(in_data);
    cd_in = pc1(in_key);
    l_n   = l_q;
    r_n   = r_q;
    c_n   = c_q;
    d_n   = d_q;
    sub   = '0;
    tmp   = '0;
    rnd   = 0;
    for (int unsigned k = 0; k < UNROLL; k++) begin
      rnd = {27'd0, cnt_q} + k + 32'd1;
`ifdef DES_DEC_ENCRYPT_EN
      if (mode_q) begin
        c_n = rotl28(c_n, enc_rot(rnd));
        d_n = rotl28(d_n, enc_rot(rnd));
      end else begin
        c_n = rotr28(c_n, dec_rot(rnd));
        d_n = rotr28(d_n, dec_rot(rnd));
      end
`else
      c_n = rotr28(c_n, dec_rot(rnd));
      d_n = rotr28(d_n, dec_rot(rnd));
`endif
      sub = pc2({c_n, d_n});
      tmp = r_n;
      r_n = l_n ^ feistel(r_n, sub);
      l_n = tmp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef DES_DEC_ENCRYPT_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            l_q     <= ip_in[63:32];
            r_q     <= ip_in[31:0];
            c_q     <= cd_in[55:28];
            d_q     <= cd_in[27:0];
            cnt_q   <= '0;
            state_q <= StRound;
`ifdef DES_DEC_ENCRYPT_EN
            mode_q  <= mode;
`endif
          end
        end
        StRound: begin
          l_q   <= l_n;
          r_q   <= r_n;
          c_q   <= c_n;
          d_q   <= d_n;
          cnt_q <= cnt_d;
          if (cnt_d == 5'd16) begin
            // Final swap: preoutput is R16||L16.
            out_data  <= ip_inv({r_n, l_n});
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_core.sv
// Self-checking bench for des_decrypt_core: known vectors, flow control, reset abort and
// randomized blocks compared against a textbook DES model (forward key schedule).
module tb_des_decrypt_core;
  localparam int unsigned UNROLL  = 1;
  localparam int unsigned EXP_LAT = 16 / UNROLL + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
`ifdef DES_DEC_ENCRYPT_EN
  logic        mode;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  des_decrypt_core #(.UNROLL(UNROLL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
`ifdef DES_DEC_ENCRYPT_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  localparam int IP [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int P [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Textbook DES: build K1..K16 by left shifts, then use them forwards or backwards.
  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk,
                                          input bit enc);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] ip, pre, res;
    logic [31:0] l, r, t, s, f;
    logic [47:0] x;
    logic [5:0]  six;
    int          q;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int n = 0; n < SHIFTS[i]; n++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) ks[i][47-j] = cd[56-PC2[j]];
    end
    for (int i = 0; i < 64; i++) ip[63-i] = blk[64-IP[i]];
    l = ip[63:32];
    r = ip[31:0];
    for (int i = 0; i < 16; i++) begin
      // E: six-bit windows over R stepping by four, wrapping around the ends.
      for (int j = 0; j < 48; j++) begin
        q = (4 * (j / 6) + (j % 6) - 1 + 32) % 32;
        x[47-j] = r[31-q];
      end
      x = x ^ (enc ? ks[i] : ks[15-i]);
      for (int b = 0; b < 8; b++) begin
        six = x[47-6*b -: 6];
        s[31-4*b -: 4] = SB[b][255 - 4 * (32 * int'(six[5]) + 16 * int'(six[0])
                                           + int'(six[4:1])) -: 4];
      end
      for (int j = 0; j < 32; j++) f[31-j] = s[32-P[j]];
      t = r;
      r = l ^ f;
      l = t;
    end
    pre = {r, l};
    res = '0;
    for (int i = 0; i < 64; i++) res[64-IP[i]] = pre[63-i];
    return res;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] key, input logic [63:0] data, input bit enc);
    in_key  = key;
    in_data = data;
`ifdef DES_DEC_ENCRYPT_EN
    mode = enc;
`else
    if (enc) $display("encrypt requested without DES_DEC_ENCRYPT_EN");
`endif
  endtask

  // One block: accept, measure latency, optionally hold off out_ready, then retire.
  task automatic run_block(input string tag, input logic [63:0] key, input logic [63:0] data,
                           input bit enc, input logic [63:0] exp, input int unsigned hold);
    int unsigned w;
    int unsigned lat;
    drive(key, data, enc);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check_eq({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(EXP_LAT));
    check_eq({tag, " data"}, out_data, exp);
    for (int i = 0; i < int'(hold); i++) tick();
    if (hold > 0) check_eq({tag, " data held"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, " out_valid cleared"}, 64'(out_valid), 64'd0);
    check_eq({tag, " in_ready back"}, 64'(in_ready), 64'd1);
  endtask

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;

  initial begin
    int unsigned bad_v, bad_d, bad_r, bad_b, n_acc, n_out, c;
    int unsigned t_out [2];
    logic [63:0] d_out [2];
    logic [63:0] k, p;
    bit acc, outp, e;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive('0, '0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("reset in_ready", 64'(in_ready), 64'd1);
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset out_data", out_data, 64'd0);
    check_eq("reset busy", 64'(busy), 64'd0);

    run_block("vec1", K1, C1, 1'b0, 64'h0123456789ABCDEF, 0);
    run_block("vec2", K2, 64'd0, 1'b0, 64'h8787878787878787, 0);

    // Backpressure: output must hold while a competing request is presented.
    drive(K1, C1, 1'b0);
    in_valid = 1'b1;
    tick();
    drive(K2, 64'd0, 1'b0);
    c = 1;
    while (!out_valid && c < 100) begin
      tick();
      c++;
    end
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1) bad_v++;
      if (out_data !== 64'h0123456789ABCDEF) bad_d++;
      if (in_ready !== 1'b0) bad_r++;
      tick();
    end
    check_eq("bp out_valid held", 64'(bad_v), 64'd0);
    check_eq("bp out_data stable", 64'(bad_d), 64'd0);
    check_eq("bp in_ready low", 64'(bad_r), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp release in_ready", 64'(in_ready), 64'd1);
    check_eq("bp release out_valid", 64'(out_valid), 64'd0);
    bad_b = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || out_valid !== 1'b0) bad_b++;
      tick();
    end
    check_eq("bp ignored request", 64'(bad_b), 64'd0);

    // Abort during round 7.
    drive(K2, 64'd0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort out_valid", 64'(out_valid), 64'd0);
    check_eq("abort in_ready", 64'(in_ready), 64'd1);
    bad_b = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0) bad_b++;
      tick();
    end
    check_eq("abort no output", 64'(bad_b), 64'd0);
    run_block("after abort", K1, C1, 1'b0, 64'h0123456789ABCDEF, 0);

    // Back-to-back with both handshakes tied high.
    n_acc = 0; n_out = 0;
    drive(K1, C1, 1'b0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (c = 0; c < 80 && n_out < 2; c++) begin
      acc  = in_valid && in_ready;
      outp = out_valid && out_ready;
      if (outp) begin
        t_out[n_out] = c;
        d_out[n_out] = out_data;
        n_out++;
      end
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc == 1) drive(K2, 64'd0, 1'b0);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("b2b outputs", 64'(n_out), 64'd2);
    if (n_out == 2) begin
      check_eq("b2b data0", d_out[0], 64'h0123456789ABCDEF);
      check_eq("b2b data1", d_out[1], 64'h8787878787878787);
      check_eq("b2b spacing", 64'(t_out[1] - t_out[0]), 64'(16 / UNROLL + 2));
    end
    out_ready = 1'b0;
    tick();

`ifdef DES_DEC_ENCRYPT_EN
    run_block("encrypt vec", K1, 64'h0123456789ABCDEF, 1'b1, C1, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
`ifdef DES_DEC_ENCRYPT_EN
      e = 1'($urandom_range(0, 1));
`else
      e = 1'b0;
`endif
      run_block($sformatf("rand%0d", i), k, p, e, des_ref(k, p, e), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
